// File: rtl/bc_mac_seq.sv
// Sequencer for one bit-serial BC-MAC column: issues an operand burst, gates the
// MAC feed, flushes the pipeline, drains the result LSB-first and offers it on a valid/ready port.
module bc_mac_seq #(
  parameter int AW       = 6,
  parameter int LW       = 6,
  parameter int PIPE_LAT = 2,
  parameter int OUT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [AW-1:0]    cmd_base,
  input  logic [LW-1:0]    cmd_len,
  input  logic             abort,
  output logic             rd_en,
  output logic [AW-1:0]    rd_addr,
  output logic             feed_en,
  output logic             sft_en,
  output logic             sft_in,
  input  logic             sum_lsb,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [OUT_W-1:0] res_data,
  output logic             busy
);

  localparam int DW = $clog2(OUT_W) + 1;
  localparam logic [LW:0]   CNT_ONE   = (LW+1)'(1);
  localparam logic [LW:0]   FLUSH_END = (LW+1)'(PIPE_LAT);
  localparam logic [DW-1:0] DRN_ONE   = DW'(1);
  localparam logic [DW-1:0] DRN_END   = DW'(OUT_W - 1);
  localparam logic [AW-1:0] ADDR_ONE  = AW'(1);

  typedef enum logic [2:0] {IDLE, ISSUE, FLUSH, DRAIN, DONE} state_t;

  state_t           state_q, state_d;
  logic [LW:0]      len_q, len_d;
  logic [LW:0]      cnt_q, cnt_d;
  logic [DW-1:0]    drn_q, drn_d;
  logic             rd_en_q, rd_en_d;
  logic [AW-1:0]    rd_addr_q, rd_addr_d;
  logic             feed_en_q, feed_en_d;
  logic             sft_en_q, sft_en_d;
  logic             res_valid_q, res_valid_d;
  logic [OUT_W-1:0] res_data_q, res_data_d;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    drn_d       = drn_q;
    rd_en_d     = rd_en_q;
    rd_addr_d   = rd_addr_q;
    feed_en_d   = rd_en_q;
    sft_en_d    = sft_en_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d    = ISSUE;
          len_d      = {1'b0, cmd_len} + CNT_ONE;
          cnt_d      = CNT_ONE;
          rd_en_d    = 1'b1;
          rd_addr_d  = cmd_base;
          res_data_d = '0;
        end
      end
      // cnt_q holds the number of reads already presented on rd_addr
      ISSUE: begin
        if (cnt_q == len_q) begin
          state_d = FLUSH;
          rd_en_d = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d     = cnt_q + CNT_ONE;
          rd_addr_d = rd_addr_q + ADDR_ONE;
        end
      end
      FLUSH: begin
        if (cnt_q == FLUSH_END) begin
          state_d  = DRAIN;
          sft_en_d = 1'b1;
          drn_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DRAIN: begin
        res_data_d = {sum_lsb, res_data_q[OUT_W-1:1]};
        if (drn_q == DRN_END) begin
          state_d     = DONE;
          sft_en_d    = 1'b0;
          res_valid_d = 1'b1;
        end else begin
          drn_d = drn_q + DRN_ONE;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d     = IDLE;
          res_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // abort overrides every transition, including a coincident result handshake
    if (abort && state_q != IDLE) begin
      state_d     = IDLE;
      rd_en_d     = 1'b0;
      feed_en_d   = 1'b0;
      sft_en_d    = 1'b0;
      res_valid_d = 1'b0;
      cnt_d       = '0;
      drn_d       = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      drn_q       <= '0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      feed_en_q   <= 1'b0;
      sft_en_q    <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      drn_q       <= drn_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      feed_en_q   <= feed_en_d;
      sft_en_q    <= sft_en_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign rd_en     = rd_en_q;
  assign rd_addr   = rd_addr_q;
  assign feed_en   = feed_en_q;
  assign sft_en    = sft_en_q;
  assign sft_in    = 1'b0;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;

endmodule

// File: tb/tb_bc_mac_seq.sv
// Self-checking bench for bc_mac_seq: table-driven and random bursts checked cycle by
// cycle against a timing model derived from the burst length, plus abort/reset sequences.
module tb_bc_mac_seq;
  localparam int AW    = 6;
  localparam int LW    = 6;
  localparam int OUT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [AW-1:0]    cmd_base;
  logic [LW-1:0]    cmd_len;
  logic             abort;
  logic             rd_en;
  logic [AW-1:0]    rd_addr;
  logic             feed_en;
  logic             sft_en;
  logic             sft_in;
  logic             sum_lsb;
  logic             res_valid;
  logic             res_ready;
  logic [OUT_W-1:0] res_data;
  logic             busy;

  int nCompared   = 0;
  int nMismatched = 0;

  bc_mac_seq #(.AW(AW), .LW(LW), .PIPE_LAT(2), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_base(cmd_base), .cmd_len(cmd_len), .abort(abort), .rd_en(rd_en),
    .rd_addr(rd_addr), .feed_en(feed_en), .sft_en(sft_en), .sft_in(sft_in),
    .sum_lsb(sum_lsb), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          base;
    int          len;
    logic [15:0] pattern;
    logic [15:0] expRes;
    int          delay;
  } vec_t;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkReset();
    checkOutput("rst_rd_en", 32'(rd_en), 32'd0);
    checkOutput("rst_rd_addr", 32'(rd_addr), 32'd0);
    checkOutput("rst_feed_en", 32'(feed_en), 32'd0);
    checkOutput("rst_sft_en", 32'(sft_en), 32'd0);
    checkOutput("rst_res_valid", 32'(res_valid), 32'd0);
    checkOutput("rst_res_data", 32'(res_data), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd1);
  endtask

  task automatic checkIdle(input string name);
    checkOutput(name, 32'({busy, cmd_ready, rd_en, feed_en, sft_en, res_valid}), 32'b010000);
  endtask

  // Present a command at the next negedge; returns right after its acceptance edge.
  task automatic applyStimulus(input int base, input int len);
    @(negedge clk);
    checkOutput("cmd_ready_pre", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_base  = AW'(base);
    cmd_len   = LW'(len);
    @(posedge clk);
  endtask

  // Cycle c is counted from the acceptance edge: reads on 1..N, feed on 2..N+1,
  // drain on N+4..N+19, result from N+20 until the handshake after 'delay' stalls.
  task automatic runBurst(input int base, input int len, input logic [15:0] pattern,
                          input logic [15:0] expRes, input int delay, input logic keepValid);
    int n    = len + 1;
    int endc = n + 20 + delay;
    logic [15:0] expV, actV;
    logic [5:0]  expAddr;
    logic        eRd, eFeed, eSft, eVal;
    for (int c = 1; c <= endc; c++) begin
      @(negedge clk);
      if (!keepValid) cmd_valid = 1'b0;
      eRd     = (c >= 1) && (c <= n);
      eFeed   = (c >= 2) && (c <= n + 1);
      eSft    = (c >= n + 4) && (c <= n + 19);
      eVal    = (c >= n + 20);
      expAddr = eRd ? 6'(base + c - 1) : 6'd0;
      expV    = {eRd, eFeed, eSft, eVal, 1'b1, 1'b0, 1'b0, 3'b000, expAddr};
      actV    = {rd_en, feed_en, sft_en, res_valid, busy, cmd_ready, sft_in, 3'b000,
                 rd_en ? rd_addr : 6'd0};
      checkOutput($sformatf("cyc%0d_b%0d_l%0d", c, base, len), 32'(actV), 32'(expV));
      if (eVal) checkOutput("res_data", 32'(res_data), 32'(expRes));
      sum_lsb   = eSft ? pattern[c - n - 4] : 1'($urandom);
      res_ready = (c >= n + 20) ? (c == endc) : 1'($urandom);
    end
    @(negedge clk);
    res_ready = 1'b0;
    checkIdle("after_handshake");
  endtask

  vec_t vecs[$];
  logic sawValid;

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_base = '0; cmd_len = '0;
    abort = 1'b0; sum_lsb = 1'b0; res_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkReset();
    rst = 1'b0;

    vecs.push_back('{base: 3,  len: 3,  pattern: 16'h0001, expRes: 16'h0001, delay: 0});
    vecs.push_back('{base: 62, len: 3,  pattern: 16'h5555, expRes: 16'h5555, delay: 1});
    vecs.push_back('{base: 5,  len: 63, pattern: 16'hA5C3, expRes: 16'hA5C3, delay: 0});
    vecs.push_back('{base: 0,  len: 0,  pattern: 16'h8000, expRes: 16'h8000, delay: 10});
    vecs.push_back('{base: 63, len: 1,  pattern: 16'hFFFF, expRes: 16'hFFFF, delay: 2});
    for (int i = 0; i < 8; i++) begin
      logic [15:0] p;
      p = 16'($urandom);
      vecs.push_back('{base: int'($urandom_range(0, 63)), len: int'($urandom_range(0, 63)),
                       pattern: p, expRes: p, delay: int'($urandom_range(0, 4))});
    end
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].base, vecs[i].len);
      runBurst(vecs[i].base, vecs[i].len, vecs[i].pattern, vecs[i].expRes, vecs[i].delay, 1'b0);
    end

    $display("[TB] held cmd_valid across a backpressured burst");
    applyStimulus(20, 2);
    runBurst(20, 2, 16'h1234, 16'h1234, 10, 1'b1);
    @(posedge clk);
    runBurst(20, 2, 16'h00F0, 16'h00F0, 0, 1'b0);

    $display("[TB] abort on second ISSUE cycle");
    applyStimulus(8, 5);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkIdle("abort_issue");
    sawValid = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (res_valid || busy) sawValid = 1'b1;
    end
    checkOutput("abort_no_result", 32'(sawValid), 32'd0);

    $display("[TB] abort in DRAIN");
    applyStimulus(1, 0);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
    end
    checkOutput("drain_sft_before_abort", 32'(sft_en), 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkIdle("abort_drain");

    $display("[TB] abort together with res_ready in DONE");
    applyStimulus(9, 0);
    for (int c = 1; c <= 21; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
    end
    checkOutput("done_valid_before_abort", 32'(res_valid), 32'd1);
    abort = 1'b1;
    res_ready = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    res_ready = 1'b0;
    checkIdle("abort_done");

    $display("[TB] synchronous reset mid-FLUSH");
    applyStimulus(10, 1);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkReset();
    applyStimulus(3, 3);
    runBurst(3, 3, 16'h0F0F, 16'h0F0F, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/bc_mac_seq.md
Name: bc_mac_seq

Overview:
Sequencer for one bit-serial BC-MAC column (4-bit activations, 8-lane weight bit-plane, registered 8-2 compression plus a registered segmented sum). It accepts a command, issues N consecutive operand-buffer reads, and gates the MAC feed. It then flushes the MAC pipeline and drains the result LSB-first with sft_en, collecting the bits into a parallel word. The parallel word is presented on a valid/ready result port. It sits between the layer scheduler (command side) and the operand SRAMs plus the MAC array (datapath side).

Parameters:
AW, 6, operand buffer address width; addresses wrap mod 2^AW
LW, 6, width of cmd_len; burst length N = cmd_len+1 (1..2^LW)
PIPE_LAT, 2, MAC internal latency from feed to sumout (compressor reg + sum reg)
OUT_W, 16, number of drained result bits (sft_en cycles)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE
cmd_base  in  AW  first operand address
cmd_len  in  LW  burst length minus one
abort  in  1  cancel the current operation, no result produced
rd_en  out  1  operand buffer read strobe (buffer read latency is 1 cycle)
rd_addr  out  AW  operand buffer read address
feed_en  out  1  MAC operand gate; when 0 the datapath forces act/weight to zero
sft_en  out  1  MAC sumout shift enable
sft_in  out  1  shift-in bit to MAC, constant 0
sum_lsb  in  1  MAC sumout[0]
res_valid  out  1  result available
res_ready  in  1  result consumed
res_data  out  OUT_W  drained result, first drained bit at bit 0
busy  out  1  state != IDLE

Behaviour:
- States: IDLE, ISSUE, FLUSH, DRAIN, DONE. All outputs are registered except cmd_ready and busy, which are decoded from state.
- Reset (rst=1 at a clk edge, any state): state=IDLE; rd_en=0, rd_addr=0, feed_en=0, sft_en=0, res_valid=0, res_data=0, and all counters 0. Reset mid-operation discards the burst; no result is produced.
- IDLE: cmd_ready=1. When cmd_valid&cmd_ready at edge T: latch base and N, then go to ISSUE.
- ISSUE: occupies cycles T+1..T+N.
  - rd_en=1 on each of these cycles.
  - rd_addr = base+i for i=0..N-1, computed mod 2^AW so that 2^AW-1 is followed by 0.
  - Then go to FLUSH.
- feed_en is rd_en delayed by one cycle, so it is high on cycles T+2..T+N+1.
- FLUSH: lasts PIPE_LAT+1 cycles (buffer read latency plus MAC latency). rd_en=0 and sft_en=0. Then go to DRAIN.
- DRAIN: lasts OUT_W cycles.
  - sft_en=1 and sft_in=0.
  - Each cycle, res_data <= {sum_lsb, res_data[OUT_W-1:1]}.
  - res_data is cleared to 0 on entry to ISSUE.
  - Then go to DONE.
- DONE: res_valid=1 and res_data is held stable until res_valid&res_ready, then go to IDLE.
  - A new command can be accepted no earlier than the cycle after the handshake (cmd_ready is IDLE-only).
- Default timing (PIPE_LAT=2, OUT_W=16): ISSUE T+1..T+N, FLUSH T+N+1..T+N+3, DRAIN T+N+4..T+N+19, res_valid first high at T+N+20.
- abort (in ISSUE, FLUSH, DRAIN or DONE): the next state is IDLE; rd_en, feed_en, sft_en and res_valid are 0 on the next cycle. abort in IDLE has no effect. When abort and res_ready coincide in DONE, abort wins (still goes to IDLE). rst has priority over abort.
- cmd_valid outside IDLE is ignored and not queued; cmd_base and cmd_len are sampled only at acceptance.
- Counters: a burst counter of width LW+1 handles N=2^LW without overflow. The drain counter is ceil(log2(OUT_W))+1 bits wide.

Test Plan:
- Basic burst: cmd_base=3, cmd_len=3, accepted at T.
  - rd_addr=3,4,5,6 with rd_en on T+1..T+4.
  - feed_en on T+2..T+5.
  - sft_en on T+8..T+23.
  - res_valid at T+24.
- Wrap: cmd_base=62, cmd_len=3 → rd_addr 62,63,0,1. cmd_len=63 → 64 reads ending at base-1 mod 64, with no early exit.
- Drain order: sum_lsb=1 only on the first DRAIN cycle → res_data=16'h0001. Alternating 1,0,… starting with 1 → 16'h5555.
- Backpressure:
  - Hold res_ready=0 for 10 cycles → res_valid and res_data stay stable and cmd_ready=0.
  - res_ready=1 → next cycle IDLE, cmd_ready=1.
  - A cmd_valid held throughout is accepted exactly once, after the return to IDLE.
- Abort:
  - abort on the 2nd ISSUE cycle → next cycle rd_en=0, feed_en=0, busy=0, and no res_valid ever.
  - abort in DRAIN → sft_en drops the next cycle.
  - abort together with res_ready in DONE → IDLE.
- Sync reset: rst=1 for 1 cycle mid-FLUSH → all outputs at their reset values on the next cycle. A command issued afterwards runs with nominal timing.
